// File: rtl/ines_pkg.sv
// Shared definitions for the iNES cartridge loader.
//   state_e            loader FSM states
//   INES_MAGIC         header bytes 0..3 ("NES" 0x1A), byte 0 in bits 7:0
//   OFF_*              header byte offsets of the fields the loader decodes
//   PRG_UNIT/CHR_UNIT  bank sizes in bytes; TRAINER_LEN trainer size in bytes
//   SUPPORTED_MAPPERS  mapper numbers the cartridge path can emulate
package ines_pkg;

  typedef enum logic [2:0] {IDLE, HDR, TRAIN, PRG, CHR, DONE, ERR} state_e;

  localparam logic [31:0] INES_MAGIC = 32'h1A53_454E;

  localparam int HDR_LEN = 16;
  localparam logic [3:0] OFF_PRG_CNT = 4'd4;
  localparam logic [3:0] OFF_CHR_CNT = 4'd5;
  localparam logic [3:0] OFF_FLAGS6  = 4'd6;
  localparam logic [3:0] OFF_FLAGS7  = 4'd7;

  localparam int PRG_UNIT    = 16384;
  localparam int CHR_UNIT    = 8192;
  localparam int TRAINER_LEN = 512;

  localparam int NUM_MAPPERS = 3;
  localparam logic [NUM_MAPPERS-1:0][7:0] SUPPORTED_MAPPERS = {8'd3, 8'd2, 8'd0};

  function automatic logic mapper_supported(input logic [7:0] m);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_MAPPERS; i++) begin
      if (SUPPORTED_MAPPERS[i] == m) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ines_header_check.sv
// Combinational decode and validation of a 16-byte iNES header.
//   hdr        header bytes, hdr[0] is the first byte of the image
//   ok         magic, bank counts and mapper are all acceptable
//   mapper_id  {flags7[7:4], flags6[7:4]}
//   mirrorv    flags6[0];  prg_ram flags6[1];  trainer flags6[2]
//   chr_ram    CHR bank count is zero (board uses CHR RAM)
//   prg_mask   PRG byte-address mask; also the last PRG byte address
//   chr_mask   CHR byte-address mask; also the last CHR byte address
module ines_header_check
  import ines_pkg::*;
#(
  parameter int PRG_ROM_DEPTH = 17,
  parameter int CHR_ROM_DEPTH = 15
) (
  input  logic [15:0][7:0]          hdr,
  output logic                      ok,
  output logic [7:0]                mapper_id,
  output logic                      mirrorv,
  output logic                      prg_ram,
  output logic                      chr_ram,
  output logic                      trainer,
  output logic [PRG_ROM_DEPTH-1:0]  prg_mask,
  output logic [CHR_ROM_DEPTH-1:0]  chr_mask
);

  // Masks are formed one bit wider than the PRG address so that a full-size
  // image (count x unit == 2^depth) does not overflow before the -1.
  localparam int MW = PRG_ROM_DEPTH + 1;

  logic [7:0]    prg_cnt, chr_cnt, flags6, flags7;
  logic [31:0]   prg_bytes, chr_bytes;
  logic          magic_ok, prg_ok, chr_ok, map_ok;
  logic [MW-1:0] prg_wide, chr_wide;
  logic          unused_bits;

  always_comb begin
    prg_cnt = hdr[OFF_PRG_CNT];
    chr_cnt = hdr[OFF_CHR_CNT];
    flags6  = hdr[OFF_FLAGS6];
    flags7  = hdr[OFF_FLAGS7];

    magic_ok  = (hdr[3:0] == INES_MAGIC);
    prg_bytes = 32'(prg_cnt) * 32'(PRG_UNIT);
    chr_bytes = 32'(chr_cnt) * 32'(CHR_UNIT);
    prg_ok    = (prg_cnt inside {8'd1, 8'd2, 8'd4, 8'd8}) &&
                (prg_bytes <= (32'd1 << PRG_ROM_DEPTH));
    chr_ok    = (chr_cnt inside {8'd0, 8'd1, 8'd2, 8'd4}) &&
                (chr_bytes <= (32'd1 << CHR_ROM_DEPTH));

    mapper_id = {flags7[7:4], flags6[7:4]};
    map_ok    = mapper_supported(mapper_id);
    ok        = magic_ok && prg_ok && chr_ok && map_ok;

    mirrorv = flags6[0];
    prg_ram = flags6[1];
    trainer = flags6[2];
    chr_ram = (chr_cnt == 8'd0);

    prg_wide = (MW'(prg_cnt) << $clog2(PRG_UNIT)) - MW'(1);
    chr_wide = (MW'(chr_cnt) << $clog2(CHR_UNIT)) - MW'(1);
    prg_mask = prg_wide[PRG_ROM_DEPTH-1:0];
    chr_mask = chr_ram ? CHR_ROM_DEPTH'(13'h1FFF) : chr_wide[CHR_ROM_DEPTH-1:0];
  end

  // Bytes 8..15, four-screen and the low nibble of flags7 are not used.
  assign unused_bits = ^{hdr[15:8], flags7[3:0], flags6[3],
                         prg_wide[MW-1], chr_wide[MW-1:CHR_ROM_DEPTH]};

endmodule

// File: rtl/ines_loader.sv
// Boot-time iNES image loader: parses the header, publishes mapper config and
// streams PRG/CHR bytes into the cartridge ROM write ports.
//   clk_cpu, rst        clock, synchronous active-high reset
//   start               begin a load (honoured in IDLE, DONE, ERR)
//   in_data/valid/ready image byte stream; in_ready depends on state only
//   wdata, prg_*/chr_*  registered write port, one cycle after acceptance
//   mapper_id .. prgram_mask  configuration, latched once the header passes
//   cfg_valid/busy/error      load status
//
// state | meaning
// IDLE  | waiting for start after reset
// HDR   | collecting the 16 header bytes
// TRAIN | discarding the 512-byte trainer
// PRG   | writing PRG ROM bytes
// CHR   | writing CHR ROM bytes
// DONE  | load complete, cfg_valid high
// ERR   | header rejected, error high
module ines_loader
  import ines_pkg::*;
#(
  parameter int PRG_ROM_DEPTH = 17,
  parameter int CHR_ROM_DEPTH = 15,
  parameter int PRG_RAM_DEPTH = 13
) (
  input  logic                      clk_cpu,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [7:0]                wdata,
  output logic                      prg_we,
  output logic [PRG_ROM_DEPTH-1:0]  prg_waddr,
  output logic                      chr_we,
  output logic [CHR_ROM_DEPTH-1:0]  chr_waddr,
  output logic [7:0]                mapper_id,
  output logic                      mirrorv,
  output logic                      prg_ram,
  output logic                      chr_ram,
  output logic [PRG_ROM_DEPTH-1:0]  prg_mask,
  output logic [CHR_ROM_DEPTH-1:0]  chr_mask,
  output logic [PRG_RAM_DEPTH-1:0]  prgram_mask,
  output logic                      cfg_valid,
  output logic                      busy,
  output logic                      error
);

  // One byte counter serves trainer, PRG and CHR; it must cover the widest.
  localparam int CW0   = (PRG_ROM_DEPTH > CHR_ROM_DEPTH) ? PRG_ROM_DEPTH : CHR_ROM_DEPTH;
  localparam int CNT_W = (CW0 > 9) ? CW0 : 9;

  state_e                   state_q, state_d;
  logic [15:0][7:0]         hdr_q, hdr_d, hdr_cur;
  logic [3:0]               hdr_idx_q, hdr_idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [7:0]               mapper_id_q, mapper_id_d;
  logic                     mirrorv_q, mirrorv_d;
  logic                     prg_ram_q, prg_ram_d;
  logic                     chr_ram_q, chr_ram_d;
  logic [PRG_ROM_DEPTH-1:0] prg_mask_q, prg_mask_d;
  logic [CHR_ROM_DEPTH-1:0] chr_mask_q, chr_mask_d;

  logic [7:0]               wdata_q, wdata_d;
  logic                     prg_we_q, prg_we_d;
  logic                     chr_we_q, chr_we_d;
  logic [PRG_ROM_DEPTH-1:0] prg_waddr_q, prg_waddr_d;
  logic [CHR_ROM_DEPTH-1:0] chr_waddr_q, chr_waddr_d;

  logic                     chk_ok, chk_mirrorv, chk_prg_ram, chk_chr_ram, chk_trainer;
  logic [7:0]               chk_mapper_id;
  logic [PRG_ROM_DEPTH-1:0] chk_prg_mask;
  logic [CHR_ROM_DEPTH-1:0] chk_chr_mask;

  logic accept, hdr_done, trn_last, prg_last, chr_last;

  assign accept   = in_valid && in_ready;
  assign hdr_done = (hdr_idx_q == 4'(HDR_LEN - 1));
  assign trn_last = (cnt_q == CNT_W'(TRAINER_LEN - 1));
  // The latched masks equal the last byte address of each region.
  assign prg_last = (cnt_q == CNT_W'(prg_mask_q));
  assign chr_last = (cnt_q == CNT_W'(chr_mask_q));

  // Validation sees the byte being accepted, so the decision and the config
  // latch happen on the same edge as the last header byte.
  always_comb begin
    hdr_cur            = hdr_q;
    hdr_cur[hdr_idx_q] = in_data;
  end

  ines_header_check #(
    .PRG_ROM_DEPTH(PRG_ROM_DEPTH),
    .CHR_ROM_DEPTH(CHR_ROM_DEPTH)
  ) u_header_check (
    .hdr       (hdr_cur),
    .ok        (chk_ok),
    .mapper_id (chk_mapper_id),
    .mirrorv   (chk_mirrorv),
    .prg_ram   (chk_prg_ram),
    .chr_ram   (chk_chr_ram),
    .trainer   (chk_trainer),
    .prg_mask  (chk_prg_mask),
    .chr_mask  (chk_chr_mask)
  );

  always_ff @(posedge clk_cpu) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: if (start) state_d = HDR;
      HDR:   if (accept && hdr_done) state_d = !chk_ok ? ERR : (chk_trainer ? TRAIN : PRG);
      TRAIN: if (accept && trn_last) state_d = PRG;
      PRG:   if (accept && prg_last) state_d = chr_ram_q ? DONE : CHR;
      CHR:   if (accept && chr_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    cfg_valid = 1'b0;
    error     = 1'b0;
    unique case (state_q)
      HDR, TRAIN, PRG, CHR: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    cfg_valid = 1'b1;
      ERR:     error     = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    hdr_d       = hdr_q;
    hdr_idx_d   = hdr_idx_q;
    cnt_d       = cnt_q;
    mapper_id_d = mapper_id_q;
    mirrorv_d   = mirrorv_q;
    prg_ram_d   = prg_ram_q;
    chr_ram_d   = chr_ram_q;
    prg_mask_d  = prg_mask_q;
    chr_mask_d  = chr_mask_q;
    wdata_d     = wdata_q;
    prg_we_d    = 1'b0;
    chr_we_d    = 1'b0;
    prg_waddr_d = prg_waddr_q;
    chr_waddr_d = chr_waddr_q;
    if (accept) begin
      unique case (state_q)
        HDR: begin
          hdr_d     = hdr_cur;
          hdr_idx_d = hdr_idx_q + 4'd1;
          if (hdr_done && chk_ok) begin
            mapper_id_d = chk_mapper_id;
            mirrorv_d   = chk_mirrorv;
            prg_ram_d   = chk_prg_ram;
            chr_ram_d   = chk_chr_ram;
            prg_mask_d  = chk_prg_mask;
            chr_mask_d  = chk_chr_mask;
          end
        end
        TRAIN: cnt_d = trn_last ? '0 : cnt_q + 1'b1;
        PRG: begin
          prg_we_d    = 1'b1;
          wdata_d     = in_data;
          prg_waddr_d = cnt_q[PRG_ROM_DEPTH-1:0];
          cnt_d       = prg_last ? '0 : cnt_q + 1'b1;
        end
        CHR: begin
          chr_we_d    = 1'b1;
          wdata_d     = in_data;
          chr_waddr_d = cnt_q[CHR_ROM_DEPTH-1:0];
          cnt_d       = chr_last ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      hdr_q       <= '0;
      hdr_idx_q   <= '0;
      cnt_q       <= '0;
      mapper_id_q <= '0;
      mirrorv_q   <= 1'b0;
      prg_ram_q   <= 1'b0;
      chr_ram_q   <= 1'b0;
      prg_mask_q  <= '0;
      chr_mask_q  <= '0;
      wdata_q     <= '0;
      prg_we_q    <= 1'b0;
      chr_we_q    <= 1'b0;
      prg_waddr_q <= '0;
      chr_waddr_q <= '0;
    end else begin
      hdr_q       <= hdr_d;
      hdr_idx_q   <= hdr_idx_d;
      cnt_q       <= cnt_d;
      mapper_id_q <= mapper_id_d;
      mirrorv_q   <= mirrorv_d;
      prg_ram_q   <= prg_ram_d;
      chr_ram_q   <= chr_ram_d;
      prg_mask_q  <= prg_mask_d;
      chr_mask_q  <= chr_mask_d;
      wdata_q     <= wdata_d;
      prg_we_q    <= prg_we_d;
      chr_we_q    <= chr_we_d;
      prg_waddr_q <= prg_waddr_d;
      chr_waddr_q <= chr_waddr_d;
    end
  end

  assign wdata       = wdata_q;
  assign prg_we      = prg_we_q;
  assign chr_we      = chr_we_q;
  assign prg_waddr   = prg_waddr_q;
  assign chr_waddr   = chr_waddr_q;
  assign mapper_id   = mapper_id_q;
  assign mirrorv     = mirrorv_q;
  assign prg_ram     = prg_ram_q;
  assign chr_ram     = chr_ram_q;
  assign prg_mask    = prg_mask_q;
  assign chr_mask    = chr_mask_q;
  assign prgram_mask = '1;

endmodule

// File: tb/tb_ines_loader.sv
// Directed bench for ines_loader: header decode table plus full-load,
// error, reset and trainer/backpressure sequences.
module tb_ines_loader;

  logic        clk_cpu = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  wdata;
  logic        prg_we, chr_we;
  logic [16:0] prg_waddr;
  logic [14:0] chr_waddr;
  logic [7:0]  mapper_id;
  logic        mirrorv, prg_ram, chr_ram;
  logic [16:0] prg_mask;
  logic [14:0] chr_mask;
  logic [12:0] prgram_mask;
  logic        cfg_valid, busy, error;

  ines_loader dut (
    .clk_cpu(clk_cpu), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wdata(wdata), .prg_we(prg_we), .prg_waddr(prg_waddr),
    .chr_we(chr_we), .chr_waddr(chr_waddr),
    .mapper_id(mapper_id), .mirrorv(mirrorv), .prg_ram(prg_ram), .chr_ram(chr_ram),
    .prg_mask(prg_mask), .chr_mask(chr_mask), .prgram_mask(prgram_mask),
    .cfg_valid(cfg_valid), .busy(busy), .error(error)
  );

  always #5 clk_cpu = ~clk_cpu;

  typedef struct {
    logic [7:0]  b0, b4, b5, b6, b7;
    logic        ok;
    logic [7:0]  mapper;
    logic        mirror, pram, cram;
    logic [16:0] pmask;
    logic [14:0] cmask;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;
  bit stuck   = 1'b0;

  // write monitor state
  bit          mon_clr = 1'b0;
  int          prg_wr_cnt = 0, chr_wr_cnt = 0, acc_cnt = 0, bad_wr = 0;
  logic [16:0] first_prg_addr = '0, last_prg_addr = '0;
  logic [7:0]  first_prg_data = '0;

  function automatic logic [7:0] pat_prg(input int a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
  endfunction
  function automatic logic [7:0] pat_chr(input int a);
    return 8'(a * 3) ^ 8'(a >> 7) ^ 8'hA5;
  endfunction
  function automatic logic [7:0] pat_trn(input int i);
    return 8'hC3 ^ 8'(i);
  endfunction

  function automatic logic [7:0] hdr_byte(input vec_t v, input int i);
    case (i)
      0: return v.b0;
      1: return 8'h45;
      2: return 8'h53;
      3: return 8'h1A;
      4: return v.b4;
      5: return v.b5;
      6: return v.b6;
      7: return v.b7;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk_cpu) begin
    if (mon_clr) begin
      prg_wr_cnt = 0; chr_wr_cnt = 0; acc_cnt = 0; bad_wr = 0;
      first_prg_addr = '0; last_prg_addr = '0; first_prg_data = '0;
    end else begin
      if (in_valid && in_ready) acc_cnt++;
      if (prg_we) begin
        if (prg_wr_cnt == 0) begin
          first_prg_addr = prg_waddr;
          first_prg_data = wdata;
        end
        if (prg_waddr !== 17'(prg_wr_cnt) || wdata !== pat_prg(prg_wr_cnt)) bad_wr++;
        last_prg_addr = prg_waddr;
        prg_wr_cnt++;
      end
      if (chr_we) begin
        if (chr_waddr !== 15'(chr_wr_cnt) || wdata !== pat_chr(chr_wr_cnt)) bad_wr++;
        chr_wr_cnt++;
      end
      if (prg_we && chr_we) bad_wr++;
    end
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk_cpu);
    #1 rst = 1'b0;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(posedge clk_cpu); #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk_cpu); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    if (stuck) return;
    in_data = b; in_valid = 1'b1; guard = 0;
    @(negedge clk_cpu);
    while (!in_ready && guard < 64) begin
      @(negedge clk_cpu);
      guard++;
    end
    if (!in_ready) begin
      stuck = 1'b1;
      in_valid = 1'b0;
      @(posedge clk_cpu); #1;
      return;
    end
    @(posedge clk_cpu); #1;
  endtask

  task automatic send_hdr(input vec_t v);
    for (int i = 0; i < 16; i++) send_byte(hdr_byte(v, i));
    in_valid = 1'b0;
  endtask

  // Stream index s counts image bytes from the first payload byte (16).
  // Before every byte with s < gap_until in_valid drops for one cycle.
  task automatic send_stream(input int n_trn, input int n_prg, input int n_chr,
                             input int gap_until, input int start_at);
    int s;
    s = 16;
    for (int k = 0; k < n_trn + n_prg + n_chr; k++) begin
      if (stuck) break;
      if (s < gap_until) begin
        in_valid = 1'b0;
        @(posedge clk_cpu); #1;
      end
      if (s == start_at) start = 1'b1;
      if (k < n_trn)              send_byte(pat_trn(k));
      else if (k < n_trn + n_prg) send_byte(pat_prg(k - n_trn));
      else                        send_byte(pat_chr(k - n_trn - n_prg));
      start = 1'b0;
      s++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  vec_t vecs [11];
  vec_t v;
  int   acc_before, wr_before;

  initial begin
    //          b0     b4     b5     b6     b7     ok    map    mir   pram  cram  pmask       cmask
    vecs[0]  = '{8'h4E, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 17'h03FFF, 15'h1FFF};
    vecs[1]  = '{8'h4E, 8'h08, 8'h00, 8'h22, 8'h00, 1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 17'h1FFFF, 15'h1FFF};
    vecs[2]  = '{8'h4E, 8'h02, 8'h04, 8'h31, 8'h00, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 17'h07FFF, 15'h7FFF};
    vecs[3]  = '{8'h4E, 8'h04, 8'h02, 8'h20, 8'h00, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 17'h0FFFF, 15'h3FFF};
    vecs[4]  = '{8'h4F, 8'h01, 8'h01, 8'h01, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 17'h0,     15'h0};
    vecs[5]  = '{8'h4E, 8'h03, 8'h01, 8'h00, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 17'h0,     15'h0};
    vecs[6]  = '{8'h4E, 8'h01, 8'h01, 8'h10, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 17'h0,     15'h0};
    vecs[7]  = '{8'h4E, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 17'h0,     15'h0};
    vecs[8]  = '{8'h4E, 8'h01, 8'h03, 8'h00, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 17'h0,     15'h0};
    vecs[9]  = '{8'h4E, 8'h01, 8'h01, 8'h00, 8'h10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 17'h0,     15'h0};
    vecs[10] = '{8'h4E, 8'h10, 8'h01, 8'h00, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 17'h0,     15'h0};

    // reset state
    do_reset();
    @(negedge clk_cpu);
    chk("reset busy", busy, 0);
    chk("reset cfg_valid", cfg_valid, 0);
    chk("reset error", error, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset strobes", {prg_we, chr_we}, 0);
    chk("reset mapper_id", mapper_id, 0);
    chk("reset masks", {prg_mask, chr_mask}, 0);
    chk("reset prgram_mask", prgram_mask, 13'h1FFF);
    @(posedge clk_cpu); #1;

    // header decode table
    for (int r = 0; r < 11; r++) begin
      do_reset();
      mon_clear();
      stuck = 1'b0;
      pulse_start();
      send_hdr(vecs[r]);
      @(negedge clk_cpu);
      chk($sformatf("row%0d error", r), error, !vecs[r].ok);
      chk($sformatf("row%0d busy", r), busy, vecs[r].ok);
      chk($sformatf("row%0d cfg_valid", r), cfg_valid, 0);
      chk($sformatf("row%0d mapper_id", r), mapper_id, vecs[r].mapper);
      chk($sformatf("row%0d mirrorv", r), mirrorv, vecs[r].mirror);
      chk($sformatf("row%0d prg_ram", r), prg_ram, vecs[r].pram);
      chk($sformatf("row%0d chr_ram", r), chr_ram, vecs[r].cram);
      chk($sformatf("row%0d prg_mask", r), prg_mask, vecs[r].pmask);
      chk($sformatf("row%0d chr_mask", r), chr_mask, vecs[r].cmask);
      repeat (2) @(negedge clk_cpu);
      chk($sformatf("row%0d no strobes", r), prg_wr_cnt + chr_wr_cnt, 0);
      chk($sformatf("row%0d stream stalled", r), stuck, 0);
      @(posedge clk_cpu); #1;
    end

    // NROM full load, start pulsed during PRG, extra bytes after DONE
    do_reset();
    mon_clear();
    stuck = 1'b0;
    pulse_start();
    send_hdr(vecs[0]);
    send_stream(0, 16384, 8192, 0, 16 + 100);
    repeat (2) @(negedge clk_cpu);
    chk("nrom stream stalled", stuck, 0);
    chk("nrom prg writes", prg_wr_cnt, 16384);
    chk("nrom chr writes", chr_wr_cnt, 8192);
    chk("nrom last prg addr", last_prg_addr, 17'h3FFF);
    chk("nrom bad writes", bad_wr, 0);
    chk("nrom accepted", acc_cnt, 16 + 16384 + 8192);
    chk("nrom cfg_valid", cfg_valid, 1);
    chk("nrom busy", busy, 0);
    chk("nrom prg_mask", prg_mask, 17'h3FFF);
    chk("nrom mirrorv", mirrorv, 1);
    acc_before = acc_cnt;
    wr_before  = prg_wr_cnt + chr_wr_cnt;
    @(posedge clk_cpu); #1;
    in_data = 8'h77; in_valid = 1'b1;
    repeat (5) @(posedge clk_cpu);
    #1 in_valid = 1'b0;
    @(negedge clk_cpu);
    chk("done extra bytes accepted", acc_cnt, acc_before);
    chk("done extra bytes written", prg_wr_cnt + chr_wr_cnt, wr_before);
    chk("done cfg holds", cfg_valid, 1);
    @(posedge clk_cpu); #1;

    // error, restart from ERR, UxROM config, reset mid-PRG
    do_reset();
    mon_clear();
    stuck = 1'b0;
    pulse_start();
    send_hdr(vecs[4]);
    @(negedge clk_cpu);
    chk("err error", error, 1);
    chk("err busy", busy, 0);
    chk("err in_ready", in_ready, 0);
    @(posedge clk_cpu); #1;
    pulse_start();
    @(negedge clk_cpu);
    chk("restart error cleared", error, 0);
    chk("restart busy", busy, 1);
    @(posedge clk_cpu); #1;
    send_hdr(vecs[1]);
    @(negedge clk_cpu);
    chk("uxrom prg_mask", prg_mask, 17'h1FFFF);
    chk("uxrom chr_ram", chr_ram, 1);
    chk("uxrom prg_ram", prg_ram, 1);
    chk("uxrom mapper_id", mapper_id, 2);
    @(posedge clk_cpu); #1;
    send_stream(0, 99, 0, 0, -1);
    // byte 100 arrives together with rst: its write must never appear
    in_data = pat_prg(99); in_valid = 1'b1; rst = 1'b1;
    @(posedge clk_cpu); #1;
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk_cpu);
    chk("rst prg_we", prg_we, 0);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst config", {mapper_id, prg_ram, chr_ram, mirrorv}, 0);
    chk("rst masks", {prg_mask, chr_mask}, 0);
    chk("rst write port", {wdata, prg_waddr, chr_waddr}, 0);
    chk("rst prgram_mask", prgram_mask, 13'h1FFF);
    repeat (3) @(negedge clk_cpu);
    chk("rst prg writes", prg_wr_cnt, 99);
    chk("rst bad writes", bad_wr, 0);
    @(posedge clk_cpu); #1;

    // reload: trainer, CHR RAM, in_valid toggling through trainer and early PRG
    mon_clear();
    stuck = 1'b0;
    pulse_start();
    v = '{8'h4E, 8'h01, 8'h00, 8'h04, 8'h00, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 17'h03FFF, 15'h1FFF};
    send_hdr(v);
    send_stream(512, 16384, 0, 16 + 600, -1);
    repeat (2) @(negedge clk_cpu);
    chk("trn stream stalled", stuck, 0);
    chk("trn first prg addr", first_prg_addr, 0);
    chk("trn first prg data", first_prg_data, pat_prg(0));
    chk("trn prg writes", prg_wr_cnt, 16384);
    chk("trn chr writes", chr_wr_cnt, 0);
    chk("trn accepted", acc_cnt, 16 + 512 + 16384);
    chk("trn strobes vs accepted", prg_wr_cnt, acc_cnt - 528);
    chk("trn bad writes", bad_wr, 0);
    chk("trn cfg_valid", cfg_valid, 1);
    chk("trn chr_ram", chr_ram, 1);
    chk("trn chr_mask", chr_mask, 15'h1FFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ines_loader.md
Name: ines_loader

Overview:
- Boot-time controller that configures and fills the cartridge mapper/memory path.
- Consumes an iNES image as a byte stream over a valid/ready handshake and parses the 16-byte header.
- Derives mapper_id, mirroring, CHR-RAM/PRG-RAM flags and address masks for the mapper bank, then sequences PRG and CHR bytes into the ROM write ports.
- Sits between the host/SD image source and the cartridge memories; cfg_valid releases the console from reset.

Parameters:
- PRG_ROM_DEPTH, 17, PRG ROM byte-address width (max 128 KB).
- CHR_ROM_DEPTH, 15, CHR ROM byte-address width (max 32 KB).
- PRG_RAM_DEPTH, 13, PRG RAM byte-address width.

Ports:
- clk_cpu  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a load from IDLE, DONE or ERR.
- in_data  in  8  image byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- wdata  out  8  write data shared by the PRG and CHR ports.
- prg_we  out  1  PRG ROM write strobe.
- prg_waddr  out  PRG_ROM_DEPTH  PRG ROM write address.
- chr_we  out  1  CHR ROM write strobe.
- chr_waddr  out  CHR_ROM_DEPTH  CHR ROM write address.
- mapper_id  out  8  {hdr7[7:4], hdr6[7:4]}.
- mirrorv  out  1  hdr6[0].
- prg_ram  out  1  hdr6[1] (battery RAM present).
- chr_ram  out  1  1 when the CHR count is 0.
- prg_mask  out  PRG_ROM_DEPTH  PRG address mask.
- chr_mask  out  CHR_ROM_DEPTH  CHR address mask.
- prgram_mask  out  PRG_RAM_DEPTH  all ones.
- cfg_valid  out  1  configuration and memories complete.
- busy  out  1  load in progress.
- error  out  1  load aborted; sticky until start or rst.

Behaviour:
- Reset: state IDLE; every output 0 except prgram_mask, which is all ones. All counters are cleared.
- Handshake: a byte is accepted when in_valid && in_ready. in_ready = 1 only in HDR, TRAIN, PRG and CHR. No combinational path from in_valid to in_ready.
- States:
  - IDLE: on start -> HDR. Clear cfg_valid and error; set busy.
  - HDR: accept 16 bytes and store them at header index 0..15. After byte 15 is accepted, validate:
    - bytes 0-3 must equal 4E 45 53 1A;
    - PRG count (byte 4) must be in {1, 2, 4, 8} and fit in 2^PRG_ROM_DEPTH;
    - CHR count (byte 5) must be in {0, 1, 2, 4} and fit in 2^CHR_ROM_DEPTH;
    - mapper must be in {0, 2, 3}.
  - On any validation failure -> ERR. Otherwise latch the config outputs and go to TRAIN if hdr6[2] is set, else PRG.
  - Config outputs keep their previous values until this latch.
  - TRAIN: accept and discard 512 bytes -> PRG.
  - PRG: accept count×16384 bytes -> CHR if the CHR count is nonzero, else DONE.
  - CHR: accept count×8192 bytes -> DONE.
  - DONE: cfg_valid = 1, busy = 0. Config holds. start -> HDR.
  - ERR: error = 1, busy = 0, cfg_valid = 0. start -> HDR.
- Masks:
  - prg_mask = count×2^14 − 1.
  - chr_mask = count×2^13 − 1; 13'h1FFF when chr_ram.
  - Width rule: compute at PRG_ROM_DEPTH+1 bits, then truncate.
- Write port:
  - Registered, one-cycle latency. The byte accepted in cycle N appears with prg_we or chr_we = 1 in cycle N+1.
  - Addresses start at 0 and increment by 1 per accepted byte.
  - The final PRG write occurs in the same cycle the state is already CHR or DONE.
  - Strobes are never both high. Trainer and header bytes never write.
- Backpressure: in_valid gaps stall counters and produce no strobes.
- Counter end test: the last byte is detected as count == size−1 on accept. No wrap, no overrun.
- start while busy: ignored.
- rst mid-load: immediate return to reset values. No further strobes, including a pending registered one.
- Stream extra bytes after DONE: not accepted (in_ready = 0).

Decomposition:
- Package ines_pkg holds:
  - state enum {IDLE, HDR, TRAIN, PRG, CHR, DONE, ERR};
  - the magic constant;
  - header byte offsets;
  - PRG_UNIT = 16384, CHR_UNIT = 8192, TRAINER_LEN = 512;
  - the supported-mapper list.
- One sub-module, ines_header_check: purely combinational. It takes the 16-byte header and produces ok, the config fields and the masks.

Test Plan:
- NROM: header 4E 45 53 1A 01 01 01 00 + 8 × 00, then 16384 + 8192 bytes -> mapper_id = 0, mirrorv = 1, prg_mask = 0x3FFF, chr_mask = 0x1FFF, 16384 prg_we then 8192 chr_we, last prg_waddr = 0x3FFF, cfg_valid = 1.
- UxROM CHR-RAM: byte4 = 08, byte5 = 00, byte6 = 0x22 (mapper 2, battery) -> prg_mask = 0x1FFFF, chr_ram = 1, prg_ram = 1, no chr_we, DONE after 131072 bytes.
- Trainer plus backpressure: byte6 = 0x04 and in_valid toggled 1-0-1 -> 512 bytes consumed with no strobes; the first prg_we has addr 0 and data equal to byte 528 of the stream; strobe count equals accepted count.
- Errors, each -> ERR and error = 1 with no strobes:
  - magic byte 0 = 4F;
  - PRG count 3;
  - mapper 1 (byte6 = 0x10).
  - A following start clears error and reloads.
- Reset mid-PRG: assert rst after 100 PRG bytes -> next cycle all outputs 0, prgram_mask all ones; no strobe after rst; a new start reloads cleanly.
- start pulsed during PRG: ignored; the load completes normally.
